// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral fronting a small register file.
// Frame layout (MSB first): R/W bit (1=write), ADDR_W address bits, DATA_W data bits.
// SCLK/COPI/nCS are oversampled in the clk domain. Register contents are
// presented flat for downstream PWM/enable logic.
module spi_regfile_peripheral #(
  parameter int NUM_REGS   = 5,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int SYNC_FLOPS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int REGS_W  = NUM_REGS * DATA_W;
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // Synchroniser chains plus one delay stage used for edge detection
  logic [SYNC_FLOPS-1:0] sclk_sync_r;
  logic [SYNC_FLOPS-1:0] copi_sync_r;
  logic [SYNC_FLOPS-1:0] ncs_sync_r;
  logic                  sclk_last_r;
  logic                  ncs_last_r;
  logic                  armed_r;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise_s, sclk_fall_s, ncs_rise_s, ncs_fall_s;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [ADDR_W-1:0]   addr_sh_r;
  logic [ADDR_W:0]     addr_sh_next_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wd_sh_r;
  logic [DATA_W-1:0]   rd_sh_r;
  logic                commit_r;
  logic                addr_valid_s;
  logic                cipo_r;
  logic                cipo_oe_r;
  logic [REGS_W-1:0]   regs_flat_r;
  logic                wr_strobe_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic                frame_err_r;

  // Register read mux; unimplemented addresses read as zero
  function automatic logic [DATA_W-1:0] reg_read(input logic [REGS_W-1:0] flat,
                                                 input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      v = (a == ADDR_W'(r)) ? flat[r*DATA_W +: DATA_W] : v;
    end
    return v;
  endfunction

  assign sclk_s = sclk_sync_r[SYNC_FLOPS-1];
  assign copi_s = copi_sync_r[SYNC_FLOPS-1];
  assign ncs_s  = ncs_sync_r[SYNC_FLOPS-1];

  assign sclk_rise_s = sclk_s & ~sclk_last_r;
  assign sclk_fall_s = ~sclk_s & sclk_last_r;
  assign ncs_rise_s  = ncs_s & ~ncs_last_r;
  // A falling nCS only starts a frame once nCS has been seen high since reset
  assign ncs_fall_s  = armed_r & ~ncs_s & ncs_last_r;

  assign addr_sh_next_s = {addr_sh_r, copi_s};
  assign addr_valid_s   = ({1'b0, addr_r} < NUM_REGS_L);

  // Input synchronisers, edge-detect delay stage and parse arming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= '0;
      copi_sync_r <= '0;
      ncs_sync_r  <= '0;
      sclk_last_r <= 1'b0;
      ncs_last_r  <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_FLOPS-2:0], sclk};
      copi_sync_r <= {copi_sync_r[SYNC_FLOPS-2:0], copi};
      ncs_sync_r  <= {ncs_sync_r[SYNC_FLOPS-2:0], ncs};
      sclk_last_r <= sclk_s;
      ncs_last_r  <= ncs_s;
      armed_r     <= armed_r | ncs_s;
    end
  end

  // Frame FSM, register file commit and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      addr_sh_r   <= '0;
      addr_r      <= '0;
      wd_sh_r     <= '0;
      rd_sh_r     <= '0;
      commit_r    <= 1'b0;
      cipo_r      <= 1'b0;
      cipo_oe_r   <= 1'b0;
      regs_flat_r <= '0;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= '0;
      frame_err_r <= 1'b0;
    end else begin
      wr_strobe_r <= 1'b0;
      frame_err_r <= 1'b0;
      commit_r    <= 1'b0;

      // Commit one clk after the last data bit; out-of-range writes vanish silently
      if (commit_r) begin
        if (addr_valid_s) begin
          for (int r = 0; r < NUM_REGS; r++) begin
            if (addr_r == ADDR_W'(r)) begin
              regs_flat_r[r*DATA_W +: DATA_W] <= wd_sh_r;
            end
          end
          wr_strobe_r <= 1'b1;
          wr_addr_r   <= addr_r;
        end else begin
          wr_strobe_r <= 1'b0;
        end
      end

      case (state_r)
        ST_IDLE: begin
          if (ncs_fall_s) begin
            state_r   <= ST_ADDR;
            cnt_r     <= '0;
            addr_sh_r <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ADDR: begin
          // nCS rise is checked first so it wins over a coincident SCLK rise
          if (ncs_rise_s) begin
            state_r     <= ST_IDLE;
            frame_err_r <= 1'b1;
            cipo_r      <= 1'b0;
            cipo_oe_r   <= 1'b0;
          end else if (ncs_fall_s) begin
            state_r   <= ST_ADDR;
            cnt_r     <= '0;
            addr_sh_r <= '0;
          end else if (sclk_rise_s) begin
            addr_sh_r <= addr_sh_next_s[ADDR_W-1:0];
            if (cnt_r == CNT_W'(ADDR_W)) begin
              addr_r <= addr_sh_next_s[ADDR_W-1:0];
              cnt_r  <= '0;
              if (addr_sh_next_s[ADDR_W]) begin
                state_r <= ST_WDATA;
              end else begin
                state_r <= ST_RDATA;
                rd_sh_r <= reg_read(regs_flat_r, addr_sh_next_s[ADDR_W-1:0]);
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= ST_ADDR;
          end
        end

        ST_WDATA: begin
          if (ncs_rise_s) begin
            state_r     <= ST_IDLE;
            frame_err_r <= 1'b1;
            cipo_r      <= 1'b0;
            cipo_oe_r   <= 1'b0;
          end else if (ncs_fall_s) begin
            state_r   <= ST_ADDR;
            cnt_r     <= '0;
            addr_sh_r <= '0;
          end else if (sclk_rise_s) begin
            wd_sh_r <= {wd_sh_r[DATA_W-2:0], copi_s};
            if (cnt_r == CNT_W'(DATA_W - 1)) begin
              state_r  <= ST_HOLD;
              commit_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= ST_WDATA;
          end
        end

        ST_RDATA: begin
          if (ncs_rise_s) begin
            state_r     <= ST_IDLE;
            frame_err_r <= 1'b1;
            cipo_r      <= 1'b0;
            cipo_oe_r   <= 1'b0;
          end else if (ncs_fall_s) begin
            state_r   <= ST_ADDR;
            cnt_r     <= '0;
            addr_sh_r <= '0;
            cipo_r    <= 1'b0;
            cipo_oe_r <= 1'b0;
          end else if (sclk_fall_s) begin
            // Present the next bit on the falling edge so it is stable at the rise
            cipo_r    <= rd_sh_r[DATA_W-1];
            cipo_oe_r <= 1'b1;
            rd_sh_r   <= {rd_sh_r[DATA_W-2:0], 1'b0};
          end else if (sclk_rise_s) begin
            if (cnt_r == CNT_W'(DATA_W - 1)) begin
              state_r <= ST_HOLD;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= ST_RDATA;
          end
        end

        ST_HOLD: begin
          // SCLK is ignored here; read data stays on CIPO until nCS rises
          if (ncs_rise_s) begin
            state_r   <= ST_IDLE;
            cipo_r    <= 1'b0;
            cipo_oe_r <= 1'b0;
          end else if (ncs_fall_s) begin
            state_r   <= ST_ADDR;
            cnt_r     <= '0;
            addr_sh_r <= '0;
            cipo_r    <= 1'b0;
            cipo_oe_r <= 1'b0;
          end else begin
            state_r <= ST_HOLD;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          cipo_r    <= 1'b0;
          cipo_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign cipo      = cipo_r;
  assign cipo_oe   = cipo_oe_r;
  assign regs_flat = regs_flat_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: writes, read-back, out-of-range
// addresses, aborted frames, back-to-back frames and reset mid-frame.
module tb_spi_regfile_peripheral;

  localparam int HALF = 8;   // SCLK half period in clk cycles

  logic        clk;
  logic        rst_n;
  logic        sclk;
  logic        copi;
  logic        ncs;
  logic        cipo;
  logic        cipo_oe;
  logic [39:0] regs_flat;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic        frame_err;

  int checks;
  int errors;
  int strobe_cnt;
  int err_cnt;
  logic [6:0] last_wr_addr;

  logic [7:0] rd;
  int         oe_hi;

  spi_regfile_peripheral #(
    .NUM_REGS(5), .ADDR_W(7), .DATA_W(8), .SYNC_FLOPS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count single-cycle output pulses away from the active edge
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt   = strobe_cnt + 1;
      last_wr_addr = wr_addr;
    end
    if (frame_err) err_cnt = err_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SPI frame; nbits < 16 gives a short frame, end_frame=0 leaves nCS low
  task automatic spi_frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                           input int nbits, input int extra, input bit end_frame,
                           output logic [7:0] rdat, output int oe_cnt);
    logic [15:0] f;
    f      = {rw, a, d};
    rdat   = '0;
    oe_cnt = 0;
    ncs    = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      copi = f[15-i];
      wait_clk(HALF);
      if (i >= 8) begin
        rdat[15-i] = cipo;
        if (cipo_oe) oe_cnt = oe_cnt + 1;
      end
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    for (int k = 0; k < extra; k++) begin
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    if (end_frame) begin
      wait_clk(HALF);
      ncs  = 1'b1;
      copi = 1'b0;
      wait_clk(4);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    strobe_cnt   = 0;
    err_cnt      = 0;
    last_wr_addr = '0;
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    wait_clk(3);

    // Reset state
    check("rst_regs", 64'(regs_flat), 64'h0);
    check("rst_cipo", 64'({cipo_oe, cipo}), 64'h0);
    check("rst_strobe_err", 64'({wr_strobe, frame_err}), 64'h0);
    check("rst_wr_addr", 64'(wr_addr), 64'h0);
    rst_n = 1'b1;
    wait_clk(8);

    // 1: write addr 2 = 0xA5
    spi_frame(1'b1, 7'd2, 8'hA5, 16, 0, 1'b1, rd, oe_hi);
    wait_clk(6);
    check("t1_strobes", 64'(strobe_cnt), 64'd1);
    check("t1_wr_addr", 64'(last_wr_addr), 64'd2);
    check("t1_regs", 64'(regs_flat), 64'h00_00_A5_00_00);
    check("t1_err", 64'(err_cnt), 64'd0);

    // 2: read addr 2, hold nCS low afterwards to see cipo_oe persist
    spi_frame(1'b0, 7'd2, 8'h00, 16, 0, 1'b0, rd, oe_hi);
    check("t2_rdata", 64'(rd), 64'hA5);
    check("t2_oe_bits", 64'(oe_hi), 64'd8);
    wait_clk(HALF * 2);
    check("t2_oe_hold", 64'({cipo_oe, cipo}), 64'b11);
    ncs = 1'b1;
    wait_clk(8);
    check("t2_oe_release", 64'({cipo_oe, cipo}), 64'b00);
    check("t2_strobes", 64'(strobe_cnt), 64'd1);

    // 3: out-of-range write dropped, out-of-range read returns zero
    spi_frame(1'b1, 7'h7F, 8'hFF, 16, 0, 1'b1, rd, oe_hi);
    wait_clk(6);
    check("t3_strobes", 64'(strobe_cnt), 64'd1);
    check("t3_err", 64'(err_cnt), 64'd0);
    check("t3_regs", 64'(regs_flat), 64'h00_00_A5_00_00);
    spi_frame(1'b0, 7'h7F, 8'hFF, 16, 0, 1'b1, rd, oe_hi);
    wait_clk(6);
    check("t3_rdata", 64'(rd), 64'h00);
    check("t3_oe_bits", 64'(oe_hi), 64'd8);

    // 4: short write (10 bits) aborts, then a full write succeeds
    spi_frame(1'b1, 7'd1, 8'hC3, 10, 0, 1'b1, rd, oe_hi);
    wait_clk(6);
    check("t4_err", 64'(err_cnt), 64'd1);
    check("t4_abort_strobes", 64'(strobe_cnt), 64'd1);
    check("t4_abort_regs", 64'(regs_flat), 64'h00_00_A5_00_00);
    spi_frame(1'b1, 7'd1, 8'h3C, 16, 0, 1'b1, rd, oe_hi);
    wait_clk(6);
    check("t4_regs", 64'(regs_flat), 64'h00_00_A5_3C_00);
    check("t4_strobes", 64'(strobe_cnt), 64'd2);

    // 5: back-to-back writes with extra SCLK pulses while holding
    for (int r = 0; r < 5; r++) begin
      spi_frame(1'b1, 7'(r), 8'(8'h11 * (r + 1)), 16, 3, 1'b1, rd, oe_hi);
    end
    wait_clk(6);
    check("t5_strobes", 64'(strobe_cnt), 64'd7);
    check("t5_regs", 64'(regs_flat), 64'h55_44_33_22_11);
    check("t5_wr_addr", 64'(last_wr_addr), 64'd4);
    check("t5_err", 64'(err_cnt), 64'd1);

    // 6: reset in the middle of a write's data phase
    spi_frame(1'b1, 7'd3, 8'h77, 16, 0, 1'b1, rd, oe_hi);
    wait_clk(6);
    check("t6_pre_regs", 64'(regs_flat), 64'h55_77_33_22_11);
    check("t6_pre_strobes", 64'(strobe_cnt), 64'd8);
    spi_frame(1'b1, 7'd3, 8'hE1, 12, 0, 1'b0, rd, oe_hi);
    rst_n = 1'b0;
    wait_clk(3);
    ncs  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    check("t6_rst_regs", 64'(regs_flat), 64'h0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(8);
    check("t6_rst_strobes", 64'(strobe_cnt), 64'd8);
    check("t6_rst_wr_addr", 64'(wr_addr), 64'd0);
    spi_frame(1'b1, 7'd4, 8'h9A, 16, 0, 1'b1, rd, oe_hi);
    wait_clk(6);
    check("t6_post_regs", 64'(regs_flat), 64'h9A_00_00_00_00);
    check("t6_post_strobes", 64'(strobe_cnt), 64'd9);
    check("t6_post_wr_addr", 64'(last_wr_addr), 64'd4);
    check("t6_err", 64'(err_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
